// File: rtl/wb_pkg.sv
// wb_pkg: shared source indices and default widths for the write-back stage
package wb_pkg;
  localparam int WB_SRC_FPU = 0;
  localparam int WB_SRC_RAM = 1;
  localparam int WB_DATA_W  = 32;
  localparam int WB_ADDR_W  = 5;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one-hot grant and winner index; round-robin pointer with WB_RR_ARB_EN, else lowest index wins
module wb_rr_arbiter #(
  parameter int NUM_SRC = 2
) (
`ifdef WB_RR_ARB_EN
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       adv,
`endif
  input  logic [NUM_SRC-1:0]         req,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_SRC);
  logic [IDX_W-1:0] base;
`ifdef WB_RR_ARB_EN
  logic [IDX_W-1:0] rr_q;
  assign base = rr_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rr_q <= '0;
    else if (adv) rr_q <= (idx == IDX_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
`else
  assign base = '0;
`endif
  // scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int j;
      j = int'(base) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (req[j]) idx = IDX_W'(j);
    end
    grant = |req ? NUM_SRC'(1) << idx : '0;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter with holding register and contention counter (WB_RR_ARB_EN selects round-robin)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  output logic                      rf_wr_en_o,
  output logic [ADDR_W-1:0]         rf_wr_addr_o,
  output logic [DATA_W-1:0]         rf_wr_data_o,
  input  logic                      rf_ready_i,
  output logic [CNT_W-1:0]          contention_cnt_o
);
  logic                       out_valid_q;
  logic [ADDR_W-1:0]          out_addr_q;
  logic [DATA_W-1:0]          out_data_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NUM_SRC-1:0]         grant;
  logic [$clog2(NUM_SRC)-1:0] idx;
  logic                       load;
  logic                       xfer;
  wb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
`ifdef WB_RR_ARB_EN
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adv   (xfer),
`endif
    .req   (src_valid_i),
    .grant (grant),
    .idx   (idx)
  );
  assign load        = !out_valid_q | rf_ready_i;
  assign src_ready_o = rst_i ? '0 : grant & {NUM_SRC{load}};
  assign xfer        = |src_ready_o;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (load) out_valid_q <= |src_valid_i;
      if (xfer) begin
        out_addr_q <= src_addr_i[idx*ADDR_W +: ADDR_W];
        out_data_q <= src_data_i[idx*DATA_W +: DATA_W];
      end
      if ($countones(src_valid_i) > 1 && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  assign rf_wr_en_o       = out_valid_q;
  assign rf_wr_addr_o     = out_addr_q;
  assign rf_wr_data_o     = out_data_q;
  assign contention_cnt_o = cnt_q;
endmodule
